// File: rtl/hpdcache_sram_ctrl_pkg.sv
`default_nettype none
// ===========================================================================
// hpdcache_sram_ctrl_pkg : shared types for the write-masked SRAM controller
// Revision: 1.0
// ===========================================================================
package hpdcache_sram_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ctrl_state_e;

  // Outstanding read responses the controller may hold (inflight + buffered)
  localparam int unsigned RSP_CREDITS = 2;

endpackage
`default_nettype wire

// File: rtl/hpdcache_sram_rsp_fifo.sv
`default_nettype none
// ===========================================================================
// hpdcache_sram_rsp_fifo : 2-entry register FIFO for SRAM read responses
// Revision: 1.0
// ===========================================================================
module hpdcache_sram_rsp_fifo #(
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] head,
  output logic [1:0]           count
);

  logic [DATA_SIZE-1:0] entry_q [2];
  logic [1:0]           count_q;

  // Entry 0 is always the head; pops shift entry 1 down
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) entry_q[0] <= push_data;
          else                 entry_q[1] <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          entry_q[0] <= entry_q[1];
          count_q    <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            entry_q[0] <= push_data;
          end else begin
            entry_q[0] <= entry_q[1];
            entry_q[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = entry_q[0];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hpdcache_sram_wmask_ctrl.sv
`default_nettype none
// ===========================================================================
// hpdcache_sram_wmask_ctrl : requester-side controller for a write-masked SRAM
// Revision: 1.0
// ===========================================================================
module hpdcache_sram_wmask_ctrl
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned DEPTH     = 2**ADDR_SIZE,
  parameter bit          INIT_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [ADDR_SIZE-1:0] req_addr_i,
  input  logic [DATA_SIZE-1:0] req_wdata_i,
  input  logic [DATA_SIZE-1:0] req_wmask_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATA_SIZE-1:0] rsp_rdata_o,
  output logic                 init_done_o,
  output logic                 sram_cs_o,
  output logic                 sram_we_o,
  output logic [ADDR_SIZE-1:0] sram_addr_o,
  output logic [DATA_SIZE-1:0] sram_wdata_o,
  output logic [DATA_SIZE-1:0] sram_wmask_o,
  input  logic [DATA_SIZE-1:0] sram_rdata_i
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR   = ADDR_SIZE'(DEPTH - 1);
  localparam ctrl_state_e          RESET_STATE = INIT_EN ? ST_INIT : ST_READY;

  ctrl_state_e          state_q, state_d;
  logic [ADDR_SIZE-1:0] init_cnt_q, init_cnt_d;
  logic                 rd_inflight_q;
  logic [1:0]           fifo_cnt;
  logic [DATA_SIZE-1:0] fifo_head;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [1:0]           credits_used;
  logic                 accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RESET_STATE;
      init_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      rd_inflight_q <= accept & ~req_we_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + ADDR_SIZE'(1);
      if (init_cnt_q == LAST_ADDR) begin
        state_d    = ST_READY;
        init_cnt_d = '0;
      end
    end
  end

  // Credits cover both buffered and inflight reads, so the FIFO can never overflow
  assign credits_used = fifo_cnt + {1'b0, rd_inflight_q};
  assign req_ready_o  = rst_n & (state_q == ST_READY) & (credits_used < 2'(RSP_CREDITS));
  assign init_done_o  = rst_n & (state_q == ST_READY);
  assign accept       = req_valid_i & req_ready_o;

  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        sram_cs_o    = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = init_cnt_q;
        sram_wmask_o = '1;
      end else if (accept) begin
        sram_cs_o    = 1'b1;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
        sram_wmask_o = req_wmask_i;
      end
    end
  end

  // In-order response: buffered data first, else bypass the SRAM output
  assign fifo_empty  = (fifo_cnt == 2'd0);
  assign fifo_push   = rd_inflight_q & ~(fifo_empty & rsp_ready_i);
  assign fifo_pop    = ~fifo_empty & rsp_ready_i;
  assign rsp_valid_o = rst_n & (fifo_empty ? rd_inflight_q : 1'b1);
  assign rsp_rdata_o = !rst_n ? '0 : (fifo_empty ? sram_rdata_i : fifo_head);

  hpdcache_sram_rsp_fifo #(
    .DATA_SIZE (DATA_SIZE)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (sram_rdata_i),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_sram_wmask_ctrl.sv
`default_nettype none
// ===========================================================================
// tb_hpdcache_sram_wmask_ctrl : randomized self-checking bench with a
// request-level memory/response model. Revision: 1.0
// ===========================================================================
`timescale 1ns/1ps
module tb_hpdcache_sram_wmask_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rst_n2;
  logic          req_valid, req_ready, req_we, rsp_valid, rsp_ready, init_done;
  logic [AW-1:0] req_addr, sram_addr;
  logic [DW-1:0] req_wdata, req_wmask, rsp_rdata;
  logic          sram_cs, sram_we;
  logic [DW-1:0] sram_wdata, sram_wmask, sram_rdata;

  logic          b_req_ready, b_rsp_valid, b_init_done, b_sram_cs, b_sram_we;
  logic [DW-1:0] b_rsp_rdata, b_sram_wdata, b_sram_wmask;
  logic [AW-1:0] b_sram_addr;

  int checks   = 0;
  int failures = 0;
  int max_fifo = 0;

  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  logic [DW-1:0] exp_q    [$];
  bit            model_ready = 1'b0;

  hpdcache_sram_wmask_ctrl #(
    .ADDR_SIZE (AW), .DATA_SIZE (DW), .DEPTH (DEPTH), .INIT_EN (1'b1)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid_i (req_valid), .req_ready_o (req_ready), .req_we_i (req_we),
    .req_addr_i (req_addr), .req_wdata_i (req_wdata), .req_wmask_i (req_wmask),
    .rsp_valid_o (rsp_valid), .rsp_ready_i (rsp_ready), .rsp_rdata_o (rsp_rdata),
    .init_done_o (init_done),
    .sram_cs_o (sram_cs), .sram_we_o (sram_we), .sram_addr_o (sram_addr),
    .sram_wdata_o (sram_wdata), .sram_wmask_o (sram_wmask), .sram_rdata_i (sram_rdata)
  );

  hpdcache_sram_wmask_ctrl #(
    .ADDR_SIZE (AW), .DATA_SIZE (DW), .DEPTH (DEPTH), .INIT_EN (1'b0)
  ) dut_noinit (
    .clk (clk), .rst_n (rst_n2),
    .req_valid_i (1'b0), .req_ready_o (b_req_ready), .req_we_i (1'b0),
    .req_addr_i ('0), .req_wdata_i ('0), .req_wmask_i ('0),
    .rsp_valid_o (b_rsp_valid), .rsp_ready_i (1'b1), .rsp_rdata_o (b_rsp_rdata),
    .init_done_o (b_init_done),
    .sram_cs_o (b_sram_cs), .sram_we_o (b_sram_we), .sram_addr_o (b_sram_addr),
    .sram_wdata_o (b_sram_wdata), .sram_wmask_o (b_sram_wmask), .sram_rdata_i ('0)
  );

  // SRAM macro: bit-masked writes; read data valid only the cycle after a read
  always @(posedge clk) begin
    sram_rdata <= $urandom;
    if (sram_cs) begin
      if (sram_we) sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  always @(negedge clk) begin
    if (int'(dut.fifo_cnt) > max_fifo) max_fifo = int'(dut.fifo_cnt);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One request-interface cycle; responses and credits checked against the model
  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                      input logic rr, output bit acc);
    int outstanding;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_wmask = wm;
    rsp_ready = rr;
    #1;
    outstanding = exp_q.size();
    check_eq("rsp_valid", rsp_valid, outstanding != 0);
    if (outstanding != 0) begin
      check_eq("rsp_rdata", rsp_rdata, exp_q[0]);
      if (rr) void'(exp_q.pop_front());
    end
    check_eq("req_ready", req_ready, model_ready && (outstanding < 2));
    acc = v && req_ready;
    check_eq("sram_cs", sram_cs, acc);
    if (acc) begin
      check_eq("sram_we", sram_we, we);
      check_eq("sram_addr", sram_addr, a);
      if (we) ref_mem[a] = (ref_mem[a] & ~wm) | (wd & wm);
      else    exp_q.push_back(ref_mem[a]);
    end
    @(negedge clk);
  endtask

  task automatic init_sweep(input bit check_b);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check_eq("init_cs", sram_cs, 1'b1);
      check_eq("init_we", sram_we, 1'b1);
      check_eq("init_addr", sram_addr, i);
      check_eq("init_wdata", sram_wdata, 0);
      check_eq("init_wmask", sram_wmask, 32'hFFFF_FFFF);
      check_eq("init_ready", req_ready, 1'b0);
      check_eq("init_done_low", init_done, 1'b0);
      check_eq("init_rsp_valid", rsp_valid, 1'b0);
      if (check_b) begin
        check_eq("noinit_cs", b_sram_cs, 1'b0);
        if (i == 0) begin
          check_eq("noinit_done", b_init_done, 1'b1);
          check_eq("noinit_ready", b_req_ready, 1'b1);
        end
      end
      @(negedge clk);
    end
    #1;
    check_eq("init_done_high", init_done, 1'b1);
    check_eq("ready_after_init", req_ready, 1'b1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bool_init: for (int i = 0; i < DEPTH; i++) sram_mem[i] = $urandom;
    rst_n = 1'b0; rst_n2 = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_cs", sram_cs, 1'b0);
    check_eq("rst_ready", req_ready, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_done", init_done, 1'b0);
    check_eq("rst_noinit_done", b_init_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; rst_n2 = 1'b1;
    init_sweep(1'b1);

    // Masked write then read of the same address
    step(1, 1, 4'd3, 32'hDEAD_BEEF, 32'hFFFF_0000, 1, acc);
    check_eq("wr_acc", acc, 1'b1);
    step(1, 0, 4'd3, 0, 0, 1, acc);
    check_eq("rd_acc", acc, 1'b1);
    #1;
    check_eq("wr_rd_valid", rsp_valid, 1'b1);
    check_eq("wr_rd_data", rsp_rdata, 32'hDEAD_0000);
    step(0, 0, 0, 0, 0, 1, acc);

    // Preload then back-to-back reads
    for (int i = 0; i < 8; i++) step(1, 1, 4'(i), 32'h100 + i, 32'hFFFF_FFFF, 1, acc);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 4'(i), 0, 0, 1, acc);
      check_eq("burst_acc", acc, 1'b1);
    end
    repeat (2) step(0, 0, 0, 0, 0, 1, acc);

    // Response backpressure exhausts credits
    step(1, 0, 4'd1, 0, 0, 0, acc);
    check_eq("bp_acc1", acc, 1'b1);
    step(1, 0, 4'd2, 0, 0, 0, acc);
    check_eq("bp_acc2", acc, 1'b1);
    step(1, 0, 4'd3, 0, 0, 0, acc);
    check_eq("bp_stall", acc, 1'b0);
    #1;
    check_eq("bp_hold", rsp_rdata, 32'h101);
    begin
      bit got3 = 1'b0;
      for (int t = 0; t < 4 && !got3; t++) begin
        step(1, 0, 4'd3, 0, 0, 1, acc);
        got3 = acc;
      end
      check_eq("bp_retry", got3, 1'b1);
    end
    repeat (3) step(0, 0, 0, 0, 0, 1, acc);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom, $urandom, $urandom_range(0, 3) != 0, acc);
    end
    repeat (4) step(0, 0, 0, 0, 0, 1, acc);

    // Reset with two reads pending
    step(1, 0, 4'd5, 0, 0, 0, acc);
    step(1, 0, 4'd6, 0, 0, 0, acc);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    check_eq("midrst_rsp_valid", rsp_valid, 1'b0);
    check_eq("midrst_ready", req_ready, 1'b0);
    check_eq("midrst_done", init_done, 1'b0);
    check_eq("midrst_cs", sram_cs, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_ready = 1'b0;
    init_sweep(1'b0);
    for (int i = 0; i < 6; i++) step(1'(i > 2), 0, 4'(i), 0, 0, 1, acc);
    repeat (2) step(0, 0, 0, 0, 0, 1, acc);

    check_eq("fifo_bound", max_fifo <= 2, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
